// File: rtl/usbkeys_pkg.sv
// ============================================================================
// Package  : usbkeys_pkg
// Brief    : Shared frame constants and FSM encodings for the usbkeys link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usbkeys_pkg;

  localparam int              MAGIC_LEN = 3;
  localparam logic [8*MAGIC_LEN-1:0] MAGIC = "key";
  localparam logic [7:0]      RES_BYTE  = 8'h00;
  localparam int              FRAME_LEN = MAGIC_LEN + 3;
  localparam int              IDX_W     = (MAGIC_LEN > 1) ? $clog2(MAGIC_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAGIC = 3'd1,
    ST_MASK  = 3'd2,
    ST_RES   = 3'd3,
    ST_CODE  = 3'd4
  } state_e;

  // Magic byte idx, counting from the first byte on the wire (MSB of MAGIC).
  function automatic logic [7:0] magic_byte(input logic [IDX_W-1:0] idx);
    return MAGIC[8*(MAGIC_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_fifo.sv
// ============================================================================
// Module   : key_fifo
// Brief    : Show-ahead synchronous FIFO holding {mask, code} key events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_dout  = mem_q[rd_ptr_q];
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/usbkeys_enc.sv
// ============================================================================
// Module   : usbkeys_enc
// Brief    : Serialises queued key events into "key" MASK 0x00 CODE byte frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usbkeys_enc
  import usbkeys_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_key,
  input  logic [7:0] i_mask,
  input  logic       i_key_valid,
  output logic       o_key_ready,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_busy
);

  logic [15:0]      fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             accept;
  logic             start;

  assign fifo_push = i_key_valid && !fifo_full;

  key_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_key_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_din   ({i_mask, i_key}),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign accept = valid_q && i_byte_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    code_d   = code_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    start    = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: start = !fifo_empty;
      ST_MAGIC: begin
        if (accept) begin
          if (idx_q == IDX_W'(MAGIC_LEN - 1)) begin
            byte_d  = mask_q;
            state_d = ST_MASK;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            byte_d = magic_byte(idx_q + IDX_W'(1));
          end
        end
      end
      ST_MASK: begin
        if (accept) begin
          byte_d  = RES_BYTE;
          state_d = ST_RES;
        end
      end
      ST_RES: begin
        if (accept) begin
          byte_d  = code_q;
          state_d = ST_CODE;
        end
      end
      ST_CODE: begin
        if (accept) begin
          if (!fifo_empty) begin
            start = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Loading the next frame on the final accept keeps frames back-to-back.
    if (start) begin
      fifo_pop = 1'b1;
      mask_d   = fifo_dout[15:8];
      code_d   = fifo_dout[7:0];
      idx_d    = '0;
      byte_d   = magic_byte('0);
      valid_d  = 1'b1;
      state_d  = ST_MAGIC;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      code_q  <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign o_key_ready  = !fifo_full;
  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_usbkeys_enc.sv
// ============================================================================
// Module   : tb_usbkeys_enc
// Brief    : Directed self-checking bench for the usbkeys_enc frame encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usbkeys_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key = '0;
  logic [7:0] mask = '0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [7:0] ob;
  logic       ob_valid;
  logic       ob_ready = 1'b1;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int accepted;
  logic kr;

  logic [7:0] got_b[$];
  int         got_c[$];
  logic [7:0] exp_m [8];
  logic [7:0] exp_c [8];

  always #5 clk = ~clk;

  usbkeys_enc #(.DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key        (key),
    .i_mask       (mask),
    .i_key_valid  (key_valid),
    .o_key_ready  (key_ready),
    .o_byte       (ob),
    .o_byte_valid (ob_valid),
    .i_byte_ready (ob_ready),
    .o_busy       (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Records every byte that will be taken on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && ob_valid && ob_ready) begin
      got_b.push_back(ob);
      got_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  function automatic logic [7:0] fbyte(input logic [7:0] m, input logic [7:0] c, input int j);
    case (j)
      0:       return 8'h6B;
      1:       return 8'h65;
      2:       return 8'h79;
      3:       return m;
      4:       return 8'h00;
      default: return c;
    endcase
  endfunction

  task automatic check_frames(input string tag, input int nf);
    chk({tag, "_len"}, got_b.size(), nf * 6);
    for (int i = 0; i < nf * 6 && i < got_b.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), got_b[i], fbyte(exp_m[i/6], exp_c[i/6], i % 6));
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), got_c[i] - got_c[i-1], 1);
    end
  endtask

  task automatic offer(input logic [7:0] m, input logic [7:0] k);
    mask = m;
    key = k;
    key_valid = 1'b1;
  endtask

  initial begin
    logic [7:0] t2 [6];
    t2 = '{8'h6B, 8'h65, 8'h79, 8'h02, 8'h00, 8'h04};

    // Reset state
    #3;
    chk("rst_valid", ob_valid, 1'b0);
    chk("rst_byte", ob, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_kready", key_ready, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_kready", key_ready, 1'b1);
    chk("post_rst_valid", ob_valid, 1'b0);

    // Single frame, latency and busy fall
    offer(8'h02, 8'h04);
    tick();
    key_valid = 1'b0;
    chk("t2_lat0", ob_valid, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_v%0d", i), ob_valid, 1'b1);
      chk($sformatf("t2_b%0d", i), ob, t2[i]);
      tick();
    end
    chk("t2_busy", busy, 1'b0);
    chk("t2_valid_end", ob_valid, 1'b0);

    // Back-pressure while MASK is presented
    offer(8'h02, 8'h04);
    tick();
    key_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_b%0d", i), ob, t2[i]);
      tick();
    end
    chk("t3_mask", ob, 8'h02);
    ob_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_hold_b%0d", i), ob, 8'h02);
      chk($sformatf("t3_hold_v%0d", i), ob_valid, 1'b1);
    end
    ob_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      chk($sformatf("t3_v%0d", i), ob_valid, 1'b1);
      chk($sformatf("t3_b%0d", i), ob, t2[i]);
      tick();
    end
    chk("t3_busy", busy, 1'b0);

    // Capacity: DEPTH in the FIFO plus one in the frame register
    ob_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      offer(8'(i), 8'(8'h10 + i));
      kr = key_ready;
      tick();
      if (kr) accepted++;
    end
    key_valid = 1'b0;
    chk("t4_accepted", accepted, 5);
    chk("t4_kready", key_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_m[i] = 8'(i);
      exp_c[i] = 8'(8'h10 + i);
    end
    got_b.delete();
    got_c.delete();
    ob_ready = 1'b1;
    wait_idle("t4_idle");
    check_frames("t4", 5);

    // Back-to-back keys with concurrent push and pop
    got_b.delete();
    got_c.delete();
    offer(8'h00, 8'h04);
    tick();
    offer(8'h02, 8'h05);
    tick();
    offer(8'h00, 8'h2C);
    tick();
    key_valid = 1'b0;
    exp_m[0] = 8'h00; exp_c[0] = 8'h04;
    exp_m[1] = 8'h02; exp_c[1] = 8'h05;
    exp_m[2] = 8'h00; exp_c[2] = 8'h2C;
    wait_idle("t5_idle");
    check_frames("t5", 3);

    // Reset two bytes into a frame with another key queued
    offer(8'h03, 8'h07);
    tick();
    offer(8'h05, 8'h09);
    tick();
    key_valid = 1'b0;
    tick();
    tick();
    chk("t6_pre_byte", ob, 8'h79);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", ob_valid, 1'b0);
    chk("t6_rst_byte", ob, 8'h00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_kready", key_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_valid", ob_valid, 1'b0);
    chk("t6_post_busy", busy, 1'b0);
    got_b.delete();
    got_c.delete();
    offer(8'h01, 8'h1E);
    tick();
    key_valid = 1'b0;
    exp_m[0] = 8'h01; exp_c[0] = 8'h1E;
    wait_idle("t6_idle");
    check_frames("t6", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
